// File: rtl/mod_addsub_pkg.sv
// Shared constants and types for the pipelined modular add/subtract unit.
//
// Contents:
//   KQ, DQ         - default Kyber and Dilithium moduli
//   LANE_W, HALF_W - lane width (one Dilithium coefficient) and half width
//                    (one packed Kyber coefficient)
//   mode_t         - per-transaction operation select, encoded to match the
//                    2-bit mode port of mod_addsub_pipe
package mod_addsub_pkg;

    localparam int unsigned KQ     = 3329;
    localparam int unsigned DQ     = 8380417;
    localparam int unsigned LANE_W = 24;
    localparam int unsigned HALF_W = 12;

    typedef enum logic [1:0] {
        MODE_K_ADDSUB = 2'b00,  // Kyber: high half add, low half subtract
        MODE_D_SUB    = 2'b01,  // Dilithium: subtract
        MODE_D_ADD    = 2'b10,  // Dilithium: add
        MODE_K_ADD    = 2'b11   // Kyber: both halves add
    } mode_t;

endpackage

// File: rtl/mod_addsub_lane.sv
// One 24-bit lane of the modular add/subtract pipeline.
//
// Stage 1 registers the raw sums/differences with their carry/borrow bit
// (13 bits per Kyber half, 25 bits for the Dilithium word) together with the
// mode. Stage 2 applies a single conditional correction and registers the
// reduced result. Both stages advance only when en_i is high.
//
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset, clears both stages
//   en_i    - pipeline advance
//   mode_i  - operation for the operands presented this cycle
//   a_i     - operand A (Kyber: {hi, lo} 12-bit halves; Dilithium: 24-bit word)
//   b_i     - operand B, same packing
//   res_o   - registered result, same packing
module mod_addsub_lane
    import mod_addsub_pkg::*;
#(
    parameter int unsigned KMOD = KQ,
    parameter int unsigned DMOD = DQ
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  mode_t             mode_i,
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    output logic [LANE_W-1:0] res_o
);

    localparam int unsigned HW1 = HALF_W + 1;
    localparam int unsigned LW1 = LANE_W + 1;

    // Moduli widened by one bit so they compare directly against raw values
    // that carry the carry/borrow in their MSB.
    localparam logic [HALF_W:0] KQ_EXT = HW1'(KMOD);
    localparam logic [LANE_W:0] DQ_EXT = LW1'(DMOD);

    logic [HALF_W-1:0] a_hi, a_lo, b_hi, b_lo;

    assign a_hi = a_i[LANE_W-1:HALF_W];
    assign a_lo = a_i[HALF_W-1:0];
    assign b_hi = b_i[LANE_W-1:HALF_W];
    assign b_lo = b_i[HALF_W-1:0];

    // ------------------------------------------------------------------
    // Stage 1: raw arithmetic
    // ------------------------------------------------------------------
    logic [HALF_W:0] hi_d, hi_q;
    logic [HALF_W:0] lo_d, lo_q;
    logic [LANE_W:0] dil_d, dil_q;
    mode_t           mode_q;

    always_comb begin
        hi_d = {1'b0, a_hi} + {1'b0, b_hi};

        // Wrapping subtraction leaves the borrow in the MSB.
        if (mode_i == MODE_K_ADDSUB) begin
            lo_d = {1'b0, a_lo} - {1'b0, b_lo};
        end else begin
            lo_d = {1'b0, a_lo} + {1'b0, b_lo};
        end

        if (mode_i == MODE_D_SUB) begin
            dil_d = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            dil_d = {1'b0, a_i} + {1'b0, b_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q   <= '0;
            lo_q   <= '0;
            dil_q  <= '0;
            mode_q <= MODE_K_ADDSUB;
        end else if (en_i) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dil_q  <= dil_d;
            mode_q <= mode_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: single conditional correction
    // ------------------------------------------------------------------
    logic [HALF_W-1:0] hi_add, lo_add, lo_sub;
    logic [LANE_W-1:0] dil_add, dil_sub;
    logic [LANE_W-1:0] res_d, res_q;

    always_comb begin
        hi_add  = HALF_W'((hi_q >= KQ_EXT) ? (hi_q - KQ_EXT) : hi_q);
        lo_add  = HALF_W'((lo_q >= KQ_EXT) ? (lo_q - KQ_EXT) : lo_q);
        // On borrow the raw value is 2^13 + d; adding q and dropping the MSB
        // yields d + q.
        lo_sub  = HALF_W'(lo_q[HALF_W] ? (lo_q + KQ_EXT) : lo_q);
        dil_add = LANE_W'((dil_q >= DQ_EXT) ? (dil_q - DQ_EXT) : dil_q);
        dil_sub = LANE_W'(dil_q[LANE_W] ? (dil_q + DQ_EXT) : dil_q);

        res_d = '0;
        unique case (mode_q)
            MODE_K_ADDSUB: res_d = {hi_add, lo_sub};
            MODE_K_ADD:    res_d = {hi_add, lo_add};
            MODE_D_SUB:    res_d = dil_sub;
            MODE_D_ADD:    res_d = dil_add;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q <= '0;
        end else if (en_i) begin
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/mod_addsub_pipe.sv
// Pipelined modular add/subtract unit for the shared Kyber/Dilithium NTT
// datapath, between the butterfly multiplier and coefficient write-back.
//
// LANES independent 24-bit lanes per transaction; each lane holds two packed
// 12-bit Kyber coefficients or one 24-bit Dilithium coefficient. Two register
// stages, valid/ready handshake, and a B_DELAY-deep delay line of raw b_data
// that can replace B per transaction.
//
// Ports:
//   clk         - clock
//   rst         - synchronous active-high reset
//   in_valid    - input transaction valid
//   in_ready    - unit accepts input this cycle
//   mode        - 00 Kyber add-hi/sub-lo, 01 Dilithium sub,
//                 10 Dilithium add, 11 Kyber add-both
//   b_sel_delay - 1: B comes from the delay line output
//   a_data      - operand A, lane i at bits [24i+23:24i]
//   b_data      - operand B, same packing
//   out_valid   - result valid
//   out_ready   - downstream accepts result
//   out_data    - result, same packing
module mod_addsub_pipe #(
    parameter int unsigned LANES   = 2,
    parameter int unsigned KQ      = mod_addsub_pkg::KQ,
    parameter int unsigned DQ      = mod_addsub_pkg::DQ,
    parameter int unsigned B_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            mode,
    input  logic                  b_sel_delay,
    input  logic [24*LANES-1:0]   a_data,
    input  logic [24*LANES-1:0]   b_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [24*LANES-1:0]   out_data
);

    import mod_addsub_pkg::*;

    localparam int unsigned W = LANES * LANE_W;

    // ------------------------------------------------------------------
    // Handshake: the whole pipeline moves together, so bubbles are kept.
    // ------------------------------------------------------------------
    logic adv;
    logic fire;
    logic v1_q, v2_q;

    assign adv       = out_ready | ~v2_q;
    assign in_ready  = adv;
    assign fire      = in_valid & adv;
    assign out_valid = v2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
        end
    end

    // ------------------------------------------------------------------
    // B delay line: shifts on every accepted transaction, whatever its
    // b_sel_delay, so the tail is the B of B_DELAY transfers ago.
    // ------------------------------------------------------------------
    logic [W-1:0] dl_q [B_DELAY];
    logic [W-1:0] b_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(B_DELAY); i++) begin
                dl_q[i] <= '0;
            end
        end else if (fire) begin
            dl_q[0] <= b_data;
            for (int i = 1; i < int'(B_DELAY); i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign b_eff = b_sel_delay ? dl_q[B_DELAY-1] : b_data;

    // ------------------------------------------------------------------
    // Lane datapaths
    // ------------------------------------------------------------------
    mode_t mode_e;

    assign mode_e = mode_t'(mode);

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        mod_addsub_lane #(
            .KMOD (KQ),
            .DMOD (DQ)
        ) u_lane (
            .clk_i  (clk),
            .rst_i  (rst),
            .en_i   (adv),
            .mode_i (mode_e),
            .a_i    (a_data[g*LANE_W +: LANE_W]),
            .b_i    (b_eff[g*LANE_W +: LANE_W]),
            .res_o  (out_data[g*LANE_W +: LANE_W])
        );
    end

endmodule
